vc_input_buffer: RTL
====================

VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: flit slots in the buffer.
REQ-002 SHALL have parameter FW, default 18: flit width, with type field at bits [FW-1:FW-2] and payload below.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port wr, input, 1 bit: upstream link offers the flit on din this cycle.
REQ-006 SHALL have port din, input, FW bits: incoming flit.
REQ-007 SHALL have port rd, input, 1 bit: read enable from the downstream read-select stage (its en_out).
REQ-008 SHALL have port dout, output, FW bits: flit at the head of the buffer (first-word fall-through).
REQ-009 SHALL have port empty, output, 1 bit: buffer holds no flits.
REQ-010 SHALL have port full, output, 1 bit: buffer holds DEPTH flits.
REQ-011 SHALL have port header, output, 1 bit: head flit is a header flit.
REQ-012 SHALL have port tailer, output, 1 bit: head flit is a tail flit.
REQ-013 SHALL have port count, output, 4 bits: number of flits stored, 0..DEPTH.
REQ-014 SHALL have port credit, output, 1 bit: one-cycle pulse returned upstream per flit freed.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 Flit type codes SHALL be: 00 invalid, 01 header, 10 body, 11 tail.
REQ-017 A read SHALL be accepted iff rd=1 and empty=0; an accepted read advances the read pointer at the clock edge.
REQ-018 rd asserted while empty SHALL be ignored: no pointer change, no credit.
REQ-019 A write SHALL be accepted iff wr=1, the flit passes the legality check (REQ-024), and either full=0 or a read is accepted in the same cycle.
REQ-020 On simultaneous accepted read and write, count SHALL be unchanged; when full, the read frees the slot the write fills.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-022 dout SHALL equal the stored flit at the read pointer combinationally; dout is don't-care while empty.
REQ-023 header SHALL equal !empty & (dout type == 01), and tailer SHALL equal !empty & (dout type == 11); both are combinational from the head flit.
REQ-024 Write-side packet FSM, states IDLE and IN_PKT, updated on every wr=1:
- IDLE + header -> IN_PKT, flit legal.
- IN_PKT + body -> IN_PKT, flit legal.
- IN_PKT + tail -> IDLE, flit legal.
- Any other combination (header in IN_PKT; body or tail in IDLE; type 00) -> illegal, flit dropped, FSM state unchanged, err set.
REQ-025 A legal flit offered while full with no accepted read SHALL be dropped, SHALL set err, and SHALL leave the FSM state unchanged.
REQ-026 The FSM SHALL advance only on accepted writes.
REQ-027 err SHALL remain 1 until reset.
REQ-028 credit SHALL pulse high for exactly one cycle, in the cycle after each accepted read; back-to-back reads SHALL give a continuous high.
REQ-029 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0); both SHALL be registered-state-derived with no combinational path from wr or rd.

Reset
REQ-030 With reset=0 at a clock edge, the block SHALL clear both pointers and count to 0, set FSM to IDLE, and drive err=0, credit=0, empty=1, full=0, header=0, tailer=0.
REQ-031 Reset SHALL override a simultaneous wr or rd; a packet in flight is discarded.
REQ-032 Memory contents SHALL not be cleared by reset.

Verification
REQ-033 Write header 0x1_0001, body 0x2_0002, tail 0x3_0003 -> count=3; header=1 with dout=0x1_0001; three reads -> tailer=1 before the last read, then empty=1, and three credit pulses each one cycle after a read.
REQ-034 Fill 8 legal flits -> full=1; 9th write alone -> dropped, err=1, count=8; then wr+rd in the same cycle -> count stays 8 and the new flit lands in the freed slot.
REQ-035 Body flit written in IDLE -> not stored, count=0, err=1, FSM stays IDLE.
REQ-036 rd=1 while empty for 4 cycles -> no pointer change, credit=0 throughout.
REQ-037 Write 12 flits with interleaved reads (pointer wrap) -> output order identical to input order.
REQ-038 reset=0 mid-packet with count=5 -> next cycle count=0, empty=1, err=0, FSM IDLE; a following header is accepted.

Source files
------------

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-VC flit FIFO with first-word fall-through head,
// write-side packet framing check, credit return and sticky error flag.
module vc_input_buffer #(
  parameter int DEPTH = 8,
  parameter int FW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [FW-1:0] din,
  input  logic          rd,
  output logic [FW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          header,
  output logic          tailer,
  output logic [3:0]    count,
  output logic          credit,
  output logic          err
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);
  localparam logic [3:0]     DEPTH_C = 4'(DEPTH);

  localparam logic [1:0] TYPE_HEADER = 2'b01;
  localparam logic [1:0] TYPE_BODY   = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  logic [FW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  pkt_state_e    state_q, state_d;
  logic          err_q, err_d;
  logic          credit_q, credit_d;

  logic          rd_accept;
  logic          wr_accept;
  logic          flit_legal;
  logic [1:0]    din_type;
  logic [1:0]    head_type;

  assign din_type  = din[FW-1:FW-2];
  assign dout      = mem[rd_ptr_q];
  assign head_type = dout[FW-1:FW-2];

  // Status flags come only from registered count, never from wr/rd.
  assign empty  = (count_q == 4'd0);
  assign full   = (count_q == DEPTH_C);
  assign count  = count_q;
  assign credit = credit_q;
  assign err    = err_q;
  assign header = !empty && (head_type == TYPE_HEADER);
  assign tailer = !empty && (head_type == TYPE_TAIL);

  assign rd_accept = rd && !empty;

  // Packet framing FSM next state plus write acceptance; a full buffer
  // still accepts a write when the same-cycle read frees a slot.
  always_comb begin
    state_d    = state_q;
    flit_legal = 1'b0;
    case (state_q)
      ST_IDLE:   flit_legal = (din_type == TYPE_HEADER);
      ST_IN_PKT: flit_legal = (din_type == TYPE_BODY) || (din_type == TYPE_TAIL);
      default:   flit_legal = 1'b0;
    endcase
    wr_accept = wr && flit_legal && (!full || rd_accept);
    if (wr_accept) begin
      if (din_type == TYPE_HEADER) begin
        state_d = ST_IN_PKT;
      end else if (din_type == TYPE_TAIL) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Pointer wrap, occupancy, credit and sticky error next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = rd_accept;
    err_d    = err_q || (wr && !wr_accept);
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any packet in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  // Flit storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule
